data_mem_mmio: RTL

- Data-side memory slave attached directly to the CPU core's MEM-stage data memory port; consumes the address, write data, byte strobes and read/write enables that the MEM stage produces each cycle.
- Backs a word-organised RAM and a small MMIO window: GPIO output register, byte-stream TX FIFO, and an optional 64-bit timer with compare interrupt.
- Read data is returned in the same cycle, because the MEM stage latches it into the MEM/WB register at the next edge.

---
 rtl/data_mem_mmio_pkg.sv | 43 ++++
 rtl/data_mem_mmio_if.sv | 19 +
 rtl/data_mem_mmio_sync_fifo.sv | 52 +++++
 rtl/data_mem_mmio.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the MEM-stage data memory slave: MMIO offsets, STATUS layout, region decode width.
package data_mem_mmio_pkg;

    localparam int unsigned REGION_W   = 4;
    localparam int unsigned OFFSET_W   = 8;
    localparam int unsigned STAT_CNT_W = 4;

    localparam logic [OFFSET_W-1:0] OFF_GPIO        = 8'h00;
    localparam logic [OFFSET_W-1:0] OFF_TXDATA      = 8'h04;
    localparam logic [OFFSET_W-1:0] OFF_STATUS      = 8'h08;
    localparam logic [OFFSET_W-1:0] OFF_MTIME_LO    = 8'h0C;
    localparam logic [OFFSET_W-1:0] OFF_MTIME_HI    = 8'h10;
    localparam logic [OFFSET_W-1:0] OFF_MTIMECMP_LO = 8'h14;
    localparam logic [OFFSET_W-1:0] OFF_MTIMECMP_HI = 8'h18;

    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_CNT_LSB   = 8;

    // STATUS register image as seen on a load
    typedef struct packed {
        logic [19:0]           rsvd_hi;
        logic [STAT_CNT_W-1:0] count;
        logic [4:0]            rsvd_lo;
        logic                  overflow;
        logic                  empty;
        logic                  full;
    } status_t;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// MEM-stage data port: address, store data/strobes, load/store enables and combinational load data.
interface data_mem_mmio_if;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_we_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_re_i;
    logic [31:0] mem_rdata_o;

    modport master (
        output mem_addr_i, mem_wdata_i, mem_we_i, mem_wstrb_i, mem_re_i,
        input  mem_rdata_o
    );

    modport slave (
        input  mem_addr_i, mem_wdata_i, mem_we_i, mem_wstrb_i, mem_re_i,
        output mem_rdata_o
    );
endinterface

// File: rtl/data_mem_mmio_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted when a pop shares the edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == PTR_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk) begin : fifo_regs
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// MEM-stage data memory slave: word RAM plus MMIO window (GPIO, TX FIFO, optional timer).
// Define DATA_MEM_MMIO_TIMER_EN to build the 64-bit mtime/mtimecmp timer and its interrupt.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_mmio_if.slave        bus,
    output logic [31:0]           gpio_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  timer_irq_o
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                   is_mmio;
    logic [OFFSET_W-1:0]    mmio_off;
    logic                   mmio_we;
    logic                   mmio_re;
    logic                   ram_we;
    logic [IDX_W-1:0]       ram_idx;
    logic [31:0]            ram_rdata;
    logic [31:0]            mmio_rdata;
    logic                   unused_addr;

    // Region and word decode; byte offset within a word is ignored
    assign is_mmio  = (bus.mem_addr_i[31 -: REGION_W] == MMIO_BASE[31 -: REGION_W]);
    assign mmio_off = {bus.mem_addr_i[OFFSET_W-1:2], 2'b00};
    assign mmio_we  = bus.mem_we_i && is_mmio;
    assign mmio_re  = bus.mem_re_i && is_mmio;
    assign ram_we   = bus.mem_we_i && !is_mmio;
    assign ram_idx  = bus.mem_addr_i[2 +: IDX_W];
    assign unused_addr = ^bus.mem_addr_i;

    // Word RAM: byte-strobed synchronous write, asynchronous read (old data on collision)
    logic [31:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin : ram_write
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb_i[b]) ram[ram_idx][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
            end
        end
    end

    assign ram_rdata = ram[ram_idx];

    // GPIO output register
    always_ff @(posedge clk) begin : gpio_reg
        if (!rst_n) begin
            gpio_o <= '0;
        end else if (mmio_we && (mmio_off == OFF_GPIO)) begin
            gpio_o <= merge_strb(gpio_o, bus.mem_wdata_i, bus.mem_wstrb_i);
        end
    end

    // TX byte FIFO
    logic                  tx_push;
    logic                  tx_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  ovf_q;
    logic                  ovf_clear;

    assign tx_push   = mmio_we && (mmio_off == OFF_TXDATA) && bus.mem_wstrb_i[0];
    assign tx_pop    = tx_valid_o && tx_ready_i;
    assign ovf_clear = mmio_we && (mmio_off == OFF_STATUS) && bus.mem_wstrb_i[0]
                       && bus.mem_wdata_i[STAT_OVF_BIT];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (bus.mem_wdata_i[7:0]),
        .pop       (tx_pop),
        .head      (tx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid_o = !fifo_empty;

    // Sticky overflow: a dropped byte outranks a same-cycle clear
    always_ff @(posedge clk) begin : ovf_reg
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (tx_push && fifo_full && !tx_pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear) begin
            ovf_q <= 1'b0;
        end
    end

    status_t status;

    always_comb begin : status_pack
        status          = '0;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.overflow = ovf_q;
        status.count    = STAT_CNT_W'(fifo_count);
    end

    // Timer read views
    logic [31:0] mtime_lo_rd;
    logic [31:0] mtime_hi_rd;
    logic [31:0] mtimecmp_lo_rd;
    logic [31:0] mtimecmp_hi_rd;

`ifdef DATA_MEM_MMIO_TIMER_EN
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic [31:0] mtime_shadow_q;
    logic        irq_q;

    // Free-running mtime; the LO read snapshots HI so the pair is coherent
    always_ff @(posedge clk) begin : timer_regs
        if (!rst_n) begin
            mtime_q        <= '0;
            mtimecmp_q     <= '1;
            mtime_shadow_q <= '0;
            irq_q          <= 1'b0;
        end else begin
            mtime_q <= mtime_q + 64'd1;
            irq_q   <= (mtime_q >= mtimecmp_q);
            if (mmio_re && (mmio_off == OFF_MTIME_LO)) begin
                mtime_shadow_q <= mtime_q[63:32];
            end
            if (mmio_we && (mmio_off == OFF_MTIMECMP_LO)) begin
                mtimecmp_q[31:0] <= merge_strb(mtimecmp_q[31:0], bus.mem_wdata_i, bus.mem_wstrb_i);
            end
            if (mmio_we && (mmio_off == OFF_MTIMECMP_HI)) begin
                mtimecmp_q[63:32] <= merge_strb(mtimecmp_q[63:32], bus.mem_wdata_i, bus.mem_wstrb_i);
            end
        end
    end

    assign timer_irq_o    = irq_q;
    assign mtime_lo_rd    = mtime_q[31:0];
    assign mtime_hi_rd    = mtime_shadow_q;
    assign mtimecmp_lo_rd = mtimecmp_q[31:0];
    assign mtimecmp_hi_rd = mtimecmp_q[63:32];
`else
    assign timer_irq_o    = 1'b0;
    assign mtime_lo_rd    = '0;
    assign mtime_hi_rd    = '0;
    assign mtimecmp_lo_rd = '0;
    assign mtimecmp_hi_rd = '0;
`endif

    // MMIO read mux; TXDATA and unmapped offsets read zero
    always_comb begin : mmio_read
        mmio_rdata = '0;
        case (mmio_off)
            OFF_GPIO:        mmio_rdata = gpio_o;
            OFF_STATUS:      mmio_rdata = status;
            OFF_MTIME_LO:    mmio_rdata = mtime_lo_rd;
            OFF_MTIME_HI:    mmio_rdata = mtime_hi_rd;
            OFF_MTIMECMP_LO: mmio_rdata = mtimecmp_lo_rd;
            OFF_MTIMECMP_HI: mmio_rdata = mtimecmp_hi_rd;
            default:         mmio_rdata = '0;
        endcase
    end

    assign bus.mem_rdata_o = !bus.mem_re_i ? 32'h0 : (is_mmio ? mmio_rdata : ram_rdata);

endmodule
